// File: rtl/commit_trace_buffer_if.sv
// Commit-stage sample bus and trace drain handshake between the CPU, the
// trace buffer and its consumer.
interface commit_trace_buffer_if #(
    parameter int CNT_W = 32
);
    logic [15:0]      cm_pc;
    logic             cm_reg_we;
    logic [3:0]       cm_reg_addr;
    logic [15:0]      cm_reg_data;
    logic             cm_mem_re;
    logic             cm_mem_we;
    logic [15:0]      cm_mem_addr;
    logic [15:0]      cm_mem_wdata;
    logic [15:0]      cm_mem_rdata;
    logic             cm_hlt;

    logic             trc_valid;
    logic             trc_ready;
    logic [3:0]       trc_flags;
    logic [15:0]      trc_pc;
    logic [3:0]       trc_reg_addr;
    logic [15:0]      trc_reg_data;
    logic [15:0]      trc_mem_addr;
    logic [15:0]      trc_mem_data;
    logic [CNT_W-1:0] trc_cycle;

    // Buffer side: samples commit signals, sources trace records.
    modport slave (
        input  cm_pc, cm_reg_we, cm_reg_addr, cm_reg_data, cm_mem_re, cm_mem_we,
               cm_mem_addr, cm_mem_wdata, cm_mem_rdata, cm_hlt, trc_ready,
        output trc_valid, trc_flags, trc_pc, trc_reg_addr, trc_reg_data,
               trc_mem_addr, trc_mem_data, trc_cycle
    );

    // Environment side: CPU commit stage plus trace consumer.
    modport master (
        output cm_pc, cm_reg_we, cm_reg_addr, cm_reg_data, cm_mem_re, cm_mem_we,
               cm_mem_addr, cm_mem_wdata, cm_mem_rdata, cm_hlt, trc_ready,
        input  trc_valid, trc_flags, trc_pc, trc_reg_addr, trc_reg_data,
               trc_mem_addr, trc_mem_data, trc_cycle
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit-stage monitor: packs each retiring instruction into a trace record,
// queues it in a FIFO, and keeps cycle/instruction/drop counters until halt.
module commit_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    commit_trace_buffer_if.slave bus,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     inst_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 overflow,
    output logic                 done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, HALTED, DONE} state_t;

    typedef struct packed {
        logic [3:0]       flags;
        logic [15:0]      pc;
        logic [3:0]       reg_addr;
        logic [15:0]      reg_data;
        logic [15:0]      mem_addr;
        logic [15:0]      mem_data;
        logic [CNT_W-1:0] cycle;
    } rec_t;

    state_t        state, state_next;
    rec_t          mem [DEPTH];
    rec_t          new_rec, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          active, push_req, push_ok, pop, full, empty, drop, retire;

    assign active   = (state == RUN);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = !empty && bus.trc_ready;
    assign push_req = active && (bus.cm_reg_we || bus.cm_mem_re || bus.cm_mem_we || bus.cm_hlt);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign retire   = active && (bus.cm_hlt || bus.cm_reg_we || bus.cm_mem_we);

    always_comb begin
        new_rec          = '0;
        new_rec.flags    = {bus.cm_hlt, bus.cm_mem_we, bus.cm_mem_re, bus.cm_reg_we};
        new_rec.pc       = bus.cm_pc;
        new_rec.reg_addr = bus.cm_reg_addr;
        new_rec.reg_data = bus.cm_reg_data;
        new_rec.mem_addr = bus.cm_mem_addr;
        new_rec.mem_data = bus.cm_mem_we ? bus.cm_mem_wdata : bus.cm_mem_rdata;
        new_rec.cycle    = cycle_count;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.cm_hlt) state_next = HALTED;
            HALTED:  if (empty)      state_next = DONE;
            DONE:                    state_next = DONE;
            default:                 state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= new_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // All counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (active && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (retire && inst_count  != '1) inst_count  <= inst_count + CNT_W'(1);
            if (drop   && drop_count  != '1) drop_count  <= drop_count + CNT_W'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Stale storage is masked so an empty buffer presents all-zero fields.
    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.trc_valid    = !empty;
    assign bus.trc_flags    = head.flags;
    assign bus.trc_pc       = head.pc;
    assign bus.trc_reg_addr = head.reg_addr;
    assign bus.trc_reg_data = head.reg_data;
    assign bus.trc_mem_addr = head.mem_addr;
    assign bus.trc_mem_data = head.mem_data;
    assign bus.trc_cycle    = head.cycle;
    assign done             = (state == DONE);
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with hand-computed expectations.
module tb_commit_trace_buffer;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] cycle_count, inst_count, drop_count;
    logic             overflow, done;
    int               n_cmp = 0;
    int               n_err = 0;

    commit_trace_buffer_if #(.CNT_W(CNT_W)) bus ();

    commit_trace_buffer #(.DEPTH(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cm_pc = '0; bus.cm_reg_we = 0; bus.cm_reg_addr = '0; bus.cm_reg_data = '0;
        bus.cm_mem_re = 0; bus.cm_mem_we = 0; bus.cm_mem_addr = '0;
        bus.cm_mem_wdata = '0; bus.cm_mem_rdata = '0; bus.cm_hlt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); bus.trc_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle(); bus.trc_ready = 1'b1; rst = 1'b1;
        step();
        n_cmp++; if (bus.trc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0d want 0", bus.trc_valid); end
        n_cmp++; if (cycle_count !== '0) begin n_err++; $display("FAIL reset_cycle got %0d want 0", cycle_count); end
        n_cmp++; if (inst_count !== '0 || drop_count !== '0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", inst_count, drop_count); end
        n_cmp++; if (overflow !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_flags got ovf=%0d done=%0d want 0/0", overflow, done); end
        n_cmp++; if (bus.trc_pc !== 16'h0 || bus.trc_cycle !== '0 || bus.trc_flags !== 4'h0) begin n_err++; $display("FAIL reset_data got pc=%h cyc=%0d fl=%b want 0", bus.trc_pc, bus.trc_cycle, bus.trc_flags); end
        rst = 1'b0;
    endtask

    task automatic test_lw_sw_load();
        do_reset();
        bus.trc_ready = 1'b1;
        bus.cm_pc = 16'h0100; bus.cm_reg_we = 1; bus.cm_reg_addr = 4'd3; bus.cm_reg_data = 16'h1234;
        bus.cm_mem_re = 1; bus.cm_mem_addr = 16'h0010; bus.cm_mem_rdata = 16'h1234;
        step();
        n_cmp++; if (bus.trc_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid got %0d want 1", bus.trc_valid); end
        n_cmp++; if (bus.trc_flags !== 4'b0011) begin n_err++; $display("FAIL lw_flags got %b want 0011", bus.trc_flags); end
        n_cmp++; if (bus.trc_mem_data !== 16'h1234 || bus.trc_mem_addr !== 16'h0010) begin n_err++; $display("FAIL lw_mem got %h@%h want 1234@0010", bus.trc_mem_data, bus.trc_mem_addr); end
        n_cmp++; if (bus.trc_reg_addr !== 4'd3 || bus.trc_reg_data !== 16'h1234 || bus.trc_pc !== 16'h0100) begin n_err++; $display("FAIL lw_reg got r%0d=%h pc=%h want r3=1234 pc=0100", bus.trc_reg_addr, bus.trc_reg_data, bus.trc_pc); end
        n_cmp++; if (bus.trc_cycle !== 0 || inst_count !== 1) begin n_err++; $display("FAIL lw_counts got cyc=%0d inst=%0d want 0/1", bus.trc_cycle, inst_count); end
        idle(); bus.cm_pc = 16'h0102; bus.cm_mem_we = 1; bus.cm_mem_addr = 16'h0020;
        bus.cm_mem_wdata = 16'hBEEF; bus.cm_mem_rdata = 16'h0000;
        step();
        n_cmp++; if (bus.trc_flags !== 4'b0100 || bus.trc_mem_data !== 16'hBEEF) begin n_err++; $display("FAIL sw_rec got fl=%b md=%h want 0100/beef", bus.trc_flags, bus.trc_mem_data); end
        n_cmp++; if (bus.trc_cycle !== 1 || inst_count !== 2) begin n_err++; $display("FAIL sw_counts got cyc=%0d inst=%0d want 1/2", bus.trc_cycle, inst_count); end
        idle(); bus.cm_mem_re = 1; bus.cm_mem_addr = 16'h0030; bus.cm_mem_rdata = 16'h5A5A; bus.cm_mem_wdata = 16'h1111;
        step();
        n_cmp++; if (bus.trc_flags !== 4'b0010 || bus.trc_mem_data !== 16'h5A5A) begin n_err++; $display("FAIL ld_rec got fl=%b md=%h want 0010/5a5a", bus.trc_flags, bus.trc_mem_data); end
        n_cmp++; if (bus.trc_cycle !== 2 || inst_count !== 2) begin n_err++; $display("FAIL ld_counts got cyc=%0d inst=%0d want 2/2", bus.trc_cycle, inst_count); end
        idle();
        step();
        n_cmp++; if (bus.trc_valid !== 1'b0 || cycle_count !== 4) begin n_err++; $display("FAIL idle_norec got v=%0d cyc=%0d want 0/4", bus.trc_valid, cycle_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.cm_reg_we = 1; bus.cm_pc = 16'(i); bus.cm_reg_data = 16'(i);
            step();
        end
        idle();
        n_cmp++; if (drop_count !== 2 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop got %0d ovf=%0d want 2/1", drop_count, overflow); end
        n_cmp++; if (inst_count !== 10 || cycle_count !== 10) begin n_err++; $display("FAIL ovf_counts got inst=%0d cyc=%0d want 10/10", inst_count, cycle_count); end
        n_cmp++; if (bus.trc_valid !== 1'b1 || bus.trc_reg_data !== 16'h0) begin n_err++; $display("FAIL ovf_hold got v=%0d d=%h want 1/0000", bus.trc_valid, bus.trc_reg_data); end
        bus.trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.trc_cycle !== CNT_W'(i) || bus.trc_reg_data !== 16'(i)) begin n_err++; $display("FAIL ovf_drain%0d got cyc=%0d d=%h want %0d", i, bus.trc_cycle, bus.trc_reg_data, i); end
            step();
        end
        n_cmp++; if (bus.trc_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %0d want 0", bus.trc_valid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.cm_reg_we = 1; bus.cm_reg_data = 16'h0100 + 16'(i);
            step();
        end
        bus.cm_reg_data = 16'h01FF; bus.trc_ready = 1'b1;
        step();
        idle();
        n_cmp++; if (drop_count !== 0 || overflow !== 1'b0) begin n_err++; $display("FAIL fpp_nodrop got %0d ovf=%0d want 0/0", drop_count, overflow); end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_d;
            exp_d = (i == 7) ? 16'h01FF : 16'h0101 + 16'(i);
            n_cmp++; if (bus.trc_valid !== 1'b1 || bus.trc_reg_data !== exp_d || bus.trc_cycle !== CNT_W'(i + 1)) begin n_err++; $display("FAIL fpp_drain%0d got v=%0d d=%h cyc=%0d want 1/%h/%0d", i, bus.trc_valid, bus.trc_reg_data, bus.trc_cycle, exp_d, i + 1); end
            step();
        end
        n_cmp++; if (bus.trc_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty got %0d want 0", bus.trc_valid); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.trc_ready = 1'b1;
        repeat (5) step();
        bus.cm_hlt = 1; bus.cm_pc = 16'h0055;
        step();
        idle();
        n_cmp++; if (bus.trc_flags !== 4'b1000 || bus.trc_cycle !== 5 || bus.trc_pc !== 16'h0055) begin n_err++; $display("FAIL hlt_rec got fl=%b cyc=%0d pc=%h want 1000/5/0055", bus.trc_flags, bus.trc_cycle, bus.trc_pc); end
        n_cmp++; if (cycle_count !== 6 || inst_count !== 1 || done !== 1'b0) begin n_err++; $display("FAIL hlt_counts got cyc=%0d inst=%0d done=%0d want 6/1/0", cycle_count, inst_count, done); end
        bus.cm_reg_we = 1; bus.cm_reg_data = 16'hDEAD;
        step();
        n_cmp++; if (bus.trc_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL hlt_pop got v=%0d done=%0d want 0/0", bus.trc_valid, done); end
        step();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL hlt_done got %0d want 1", done); end
        repeat (3) step();
        n_cmp++; if (done !== 1'b1 || cycle_count !== 6 || inst_count !== 1 || bus.trc_valid !== 1'b0) begin n_err++; $display("FAIL hlt_frozen got done=%0d cyc=%0d inst=%0d v=%0d want 1/6/1/0", done, cycle_count, inst_count, bus.trc_valid); end
        idle();
    endtask

    task automatic test_halt_dropped();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.cm_reg_we = 1; bus.cm_reg_data = 16'(i);
            step();
        end
        idle(); bus.cm_hlt = 1;
        step();
        idle(); bus.cm_reg_we = 1;
        step();
        idle();
        n_cmp++; if (drop_count !== 1 || overflow !== 1'b1 || inst_count !== 9 || cycle_count !== 9) begin n_err++; $display("FAIL hdrop_counts got drop=%0d ovf=%0d inst=%0d cyc=%0d want 1/1/9/9", drop_count, overflow, inst_count, cycle_count); end
        bus.trc_ready = 1'b1;
        repeat (8) step();
        n_cmp++; if (bus.trc_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL hdrop_drained got v=%0d done=%0d want 0/0", bus.trc_valid, done); end
        step();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL hdrop_done got %0d want 1", done); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.cm_reg_we = 1; bus.cm_pc = 16'h0200 + 16'(i);
            step();
        end
        idle(); bus.trc_ready = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.trc_valid !== 1'b0 || bus.trc_pc !== 16'h0) begin n_err++; $display("FAIL mrst_valid got v=%0d pc=%h want 0/0000", bus.trc_valid, bus.trc_pc); end
        n_cmp++; if (cycle_count !== 0 || inst_count !== 0 || drop_count !== 0) begin n_err++; $display("FAIL mrst_counts got %0d/%0d/%0d want 0/0/0", cycle_count, inst_count, drop_count); end
        step();
        rst = 1'b0;
        bus.cm_reg_we = 1; bus.cm_reg_data = 16'h0077;
        step();
        idle();
        n_cmp++; if (bus.trc_valid !== 1'b1 || bus.trc_reg_data !== 16'h0077 || bus.trc_cycle !== 0) begin n_err++; $display("FAIL mrst_resume got v=%0d d=%h cyc=%0d want 1/0077/0", bus.trc_valid, bus.trc_reg_data, bus.trc_cycle); end
        n_cmp++; if (cycle_count !== 1 || inst_count !== 1 || done !== 1'b0) begin n_err++; $display("FAIL mrst_run got cyc=%0d inst=%0d done=%0d want 1/1/0", cycle_count, inst_count, done); end
    endtask

    initial begin
        idle();
        bus.trc_ready = 1'b0;
        test_reset();
        test_lw_sw_load();
        test_overflow();
        test_full_push_pop();
        test_halt();
        test_halt_dropped();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable commit-stage monitor between the cpu writeback/memory stage and the trace/log consumer (simulation bench or debug port).
- Each cycle, samples the retiring instruction's register-write, memory and halt signals and packs them into one trace record.
- Buffers records in a FIFO drained by a valid/ready handshake.
- Maintains cycle and instruction counters, and signals when the processor has halted and all records have drained.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, 32, width of cycle, instruction and drop counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cm_pc  in  16  PC of the committing instruction
cm_reg_we  in  1  register file written this cycle
cm_reg_addr  in  4  destination register
cm_reg_data  in  16  register write data
cm_mem_re  in  1  data memory read this cycle
cm_mem_we  in  1  data memory write this cycle
cm_mem_addr  in  16  data memory address
cm_mem_wdata  in  16  store data
cm_mem_rdata  in  16  load data
cm_hlt  in  1  HLT committing this cycle
trc_valid  out  1  record available at head
trc_ready  in  1  consumer accepts head record
trc_flags  out  4  {hlt, mem_we, mem_re, reg_we}
trc_pc  out  16  record PC
trc_reg_addr  out  4  record destination register
trc_reg_data  out  16  record register write data
trc_mem_addr  out  16  record memory address
trc_mem_data  out  16  store data if mem_we, else load data
trc_cycle  out  CNT_W  cycle stamp of record
cycle_count  out  CNT_W  cycles spent in RUN
inst_count  out  CNT_W  instructions retired
drop_count  out  CNT_W  records lost to overflow
overflow  out  1  sticky: at least one record dropped
done  out  1  halted and FIFO drained

Behaviour:
- Reset (async, any time, including mid-drain):
  - state = RUN; FIFO emptied.
  - All counters 0; overflow, done and trc_valid = 0.
  - trc_* data outputs = 0.
- States: RUN -> HALTED -> DONE.
  - RUN -> HALTED on the clock edge of a cycle with cm_hlt = 1.
  - HALTED -> DONE on the first edge at which the FIFO is empty. A halt captured into an empty FIFO still passes through HALTED for at least one cycle while the record drains.
  - DONE is sticky until rst.
  - done = 1 only in DONE.
  - In HALTED/DONE all cm_* inputs are ignored; no capture; no counter changes.
- Capture (RUN only):
  - A push occurs when cm_reg_we | cm_mem_re | cm_mem_we | cm_hlt = 1.
  - The record latches all cm_* fields.
  - trc_cycle = cycle_count value before that edge's increment (first cycle after reset = 0).
  - trc_mem_data = cm_mem_wdata if cm_mem_we, else cm_mem_rdata.
  - A cycle with no flag set produces no record.
- Counters (RUN only):
  - cycle_count += 1 every cycle, including the halt cycle.
  - inst_count += 1 when cm_hlt | cm_reg_we | cm_mem_we. A load-only flag (cm_mem_re alone) does not count.
  - Counting is independent of whether the record was dropped.
  - All counters saturate at all-ones; no wrap.
- FIFO:
  - Registered, no bypass: a record pushed at edge N is visible at the head (trc_valid = 1) after edge N.
  - trc_valid = not empty. trc_* fields show the head record and are held stable while trc_valid & !trc_ready.
  - Pop on trc_valid & trc_ready at the edge.
  - Push and pop in the same cycle: both occur; occupancy unchanged; this also applies when full.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Overflow:
  - Push while full with no pop in the same cycle: the record is discarded, drop_count += 1 (saturating) and overflow is set sticky.
  - The discarded record may be the halt record. The state transition to HALTED still occurs; done then follows the FIFO draining.
- trc_ready while the FIFO is empty has no effect.

Test Plan:
- Reset, then LW-style cycle (reg_we=1, addr=3, data=0x1234; mem_re=1, mem_addr=0x0010, rdata=0x1234) with trc_ready=1 -> next cycle trc_valid=1, flags=0b0011, trc_mem_data=0x1234, trc_cycle=0; inst_count=1.
- SW cycle (mem_we=1, mem_addr=0x0020, wdata=0xBEEF, rdata=0x0000) -> flags=0b0100, trc_mem_data=0xBEEF; load-only cycle (mem_re=1) -> record pushed, inst_count unchanged.
- trc_ready=0, 10 consecutive reg_we cycles with DEPTH=8 -> 8 records held; drop_count=2; overflow=1; then trc_ready=1 -> records 0..7 drain in order with trc_cycle 0..7.
- Full FIFO with push and pop in the same cycle -> no drop; occupancy stays 8; the new record is at the tail.
- cm_hlt at cycle 5 with trc_ready=1 -> cycle_count frozen at 6; later cm_reg_we ignored; done=1 one cycle after the halt record pops; done remains 1.
- rst pulsed mid-drain with 4 records queued -> trc_valid=0 and all counters 0 immediately (asynchronous); state back to RUN; capture resumes on the next active cycle.
